// File: rtl/fifo_status_ctrl_mo_if.sv
// Request / completion handshake between the FIFO-status controller and the AXI master.
interface fifo_status_ctrl_mo_if #(
    parameter int unsigned LSIZE = 9
);
    logic             req_valid;
    logic             req_tail;
    logic [LSIZE-1:0] req_len;
    logic             resp;
    logic             done;

    modport master (output req_valid, output req_tail, output req_len, input resp, input done);
    modport slave  (input req_valid, input req_tail, input req_len, output resp, output done);
endinterface

// File: rtl/fifo_status_ctrl_mo.sv
// FIFO-status burst controller: watches a stream FIFO level and issues burst/tail
// requests, tracking up to MAX_OSTD in-flight request lengths so it never over-requests.
module fifo_status_ctrl_mo #(
    parameter int unsigned CW         = 10,
    parameter int unsigned FULL_LEN   = 256,
    parameter int unsigned LSIZE      = 9,
    parameter int unsigned MAX_OSTD   = 4,
    parameter int unsigned SETTLE_CYC = 31,
    parameter string       WR_RD      = "READ",
    parameter string       MODE       = "ONCE"
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CW-1:0]         count,
    input  logic [CW-1:0]         threshold,
    input  logic [LSIZE-1:0]      burst_len,
    input  logic                  fsync,
    input  logic                  tail_status,
    input  logic [LSIZE-1:0]      tail_len,
    input  logic                  frame_tail_leave,
    fifo_status_ctrl_mo_if.master bus,
    output logic                  burst_done,
    output logic                  tail_done,
    output logic [3:0]            outstanding,
    output logic                  err_orphan
);
    localparam int unsigned PEND_W   = CW + LSIZE;
    localparam int unsigned CMP_W    = CW + LSIZE + 1;
    localparam int unsigned PTR_W    = (MAX_OSTD > 1) ? $clog2(MAX_OSTD) : 1;
    localparam int unsigned SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam bit          IS_WRITE = (WR_RD == "WRITE");
    localparam bit          IS_LINE  = (MODE == "LINE");

    typedef enum logic [2:0] {
        S_SETTLE, S_RUN, S_TAIL_WAIT, S_LAST, S_LAST_WAIT, S_HOLD
    } state_t;

    state_t             state;
    logic [SET_W-1:0]   settle_cnt;
    logic [PEND_W-1:0]  pending;
    logic               trig;
    logic               req_valid;
    logic               req_tail;
    logic [LSIZE-1:0]   req_len;
    logic [LSIZE-1:0]   len_q [MAX_OSTD];
    logic               tail_q [MAX_OSTD];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic               issue_tail;
    logic [LSIZE-1:0]   cand_len;
    logic               fits;
    logic               trig_c;
    logic               accept;
    logic               pop;
    logic [CMP_W-1:0]   cnt_x;
    logic [CMP_W-1:0]   pend_x;
    logic [CMP_W-1:0]   len_x;
    logic [CMP_W-1:0]   thr_x;

    assign bus.req_valid = req_valid;
    assign bus.req_tail  = req_tail;
    assign bus.req_len   = req_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OSTD - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue qualification: candidate length and FIFO-room check with headroom for in-flight lengths.
    always_comb begin
        issue_tail = tail_status || (state == S_LAST);
        cand_len   = issue_tail ? tail_len : burst_len;
        cnt_x      = CMP_W'(count);
        pend_x     = CMP_W'(pending);
        len_x      = CMP_W'(cand_len);
        thr_x      = CMP_W'(threshold);
        if (IS_WRITE) begin
            fits = (cnt_x >= pend_x + len_x) && (cnt_x > pend_x + thr_x);
        end else begin
            fits = (cnt_x + pend_x + len_x <= CMP_W'(FULL_LEN)) &&
                   (cnt_x + pend_x + thr_x < CMP_W'(FULL_LEN));
        end
        trig_c = enable && !fsync && ((state == S_RUN) || (state == S_LAST)) &&
                 (outstanding < 4'(MAX_OSTD)) && !trig && !req_valid && fits;
        accept = req_valid && bus.resp;
        pop    = bus.done && (outstanding != 4'd0);
    end

    // Control FSM, request handshake and in-order length accounting.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= S_SETTLE;
            settle_cnt  <= '0;
            pending     <= '0;
            trig        <= 1'b0;
            req_valid   <= 1'b0;
            req_tail    <= 1'b0;
            req_len     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= 4'd0;
            burst_done  <= 1'b0;
            tail_done   <= 1'b0;
            err_orphan  <= 1'b0;
            for (int unsigned k = 0; k < MAX_OSTD; k++) begin
                len_q[k]  <= '0;
                tail_q[k] <= 1'b0;
            end
        end else if (fsync && (state != S_SETTLE)) begin
            // Frame abort: forget everything in flight; late completions become orphans.
            state       <= S_SETTLE;
            settle_cnt  <= '0;
            pending     <= '0;
            trig        <= 1'b0;
            req_valid   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= 4'd0;
            burst_done  <= 1'b0;
            tail_done   <= 1'b0;
            err_orphan  <= bus.done && (outstanding == 4'd0);
        end else begin
            burst_done <= pop && !tail_q[rd_ptr];
            err_orphan <= bus.done && (outstanding == 4'd0);
            tail_done  <= 1'b0;
            if (accept) begin
                len_q[wr_ptr]  <= req_len;
                tail_q[wr_ptr] <= req_tail;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            outstanding <= outstanding + 4'(accept) - 4'(pop);
            pending     <= pending + (accept ? PEND_W'(req_len) : '0)
                                   - (pop ? PEND_W'(len_q[rd_ptr]) : '0);
            trig <= trig_c;
            if (trig_c) begin
                req_len  <= cand_len;
                req_tail <= issue_tail;
            end
            if (accept) begin
                req_valid <= 1'b0;
            end else if (trig) begin
                req_valid <= 1'b1;
            end
            case (state)
                S_SETTLE: begin
                    if (fsync) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        settle_cnt <= '0;
                        state      <= S_RUN;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept && req_tail) begin
                        state <= S_TAIL_WAIT;
                    end
                end
                S_TAIL_WAIT: begin
                    if (outstanding == 4'd0) begin
                        tail_done <= 1'b1;
                        state     <= IS_LINE ? (frame_tail_leave ? S_LAST : S_RUN) : S_HOLD;
                    end
                end
                S_LAST: begin
                    if (accept) begin
                        state <= S_LAST_WAIT;
                    end
                end
                S_LAST_WAIT: begin
                    if (outstanding == 4'd0) begin
                        tail_done <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    state <= S_HOLD;
                end
                default: begin
                    state <= S_SETTLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_status_ctrl_mo.sv
// Bench for fifo_status_ctrl_mo: instance 0 is READ/LINE, instance 1 is WRITE/ONCE.
// A queue-based behavioural model runs alongside both and is compared every cycle.
module tb_fifo_status_ctrl_mo;
    localparam int ST_SETTLE = 0, ST_RUN = 1, ST_TWAIT = 2, ST_LAST = 3, ST_LWAIT = 4, ST_HOLD = 5;
    localparam int FULL = 256, MAXO = 4, SETTLE = 31;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    logic       en [2];
    logic [9:0] cnt [2];
    logic [9:0] thr [2];
    logic [8:0] bl [2];
    logic       fs [2];
    logic       ts [2];
    logic [8:0] tl [2];
    logic       ftl [2];
    logic       resp [2];
    logic       dn [2];
    logic       rv [2];
    logic       rt [2];
    logic [8:0] rl [2];
    logic       bdone [2];
    logic       tdone [2];
    logic       orph [2];
    logic [3:0] ost [2];

    fifo_status_ctrl_mo_if #(.LSIZE(9)) bif0 ();
    fifo_status_ctrl_mo_if #(.LSIZE(9)) bif1 ();
    assign bif0.resp = resp[0];
    assign bif0.done = dn[0];
    assign bif1.resp = resp[1];
    assign bif1.done = dn[1];
    assign rv[0] = bif0.req_valid;
    assign rt[0] = bif0.req_tail;
    assign rl[0] = bif0.req_len;
    assign rv[1] = bif1.req_valid;
    assign rt[1] = bif1.req_tail;
    assign rl[1] = bif1.req_len;

    fifo_status_ctrl_mo #(.CW(10), .FULL_LEN(256), .LSIZE(9), .MAX_OSTD(4), .SETTLE_CYC(31),
                          .WR_RD("READ"), .MODE("LINE")) dut_rd (
        .clock(clock), .rst(rst), .enable(en[0]), .count(cnt[0]), .threshold(thr[0]),
        .burst_len(bl[0]), .fsync(fs[0]), .tail_status(ts[0]), .tail_len(tl[0]),
        .frame_tail_leave(ftl[0]), .bus(bif0), .burst_done(bdone[0]), .tail_done(tdone[0]),
        .outstanding(ost[0]), .err_orphan(orph[0]));

    fifo_status_ctrl_mo #(.CW(10), .FULL_LEN(256), .LSIZE(9), .MAX_OSTD(4), .SETTLE_CYC(31),
                          .WR_RD("WRITE"), .MODE("ONCE")) dut_wr (
        .clock(clock), .rst(rst), .enable(en[1]), .count(cnt[1]), .threshold(thr[1]),
        .burst_len(bl[1]), .fsync(fs[1]), .tail_status(ts[1]), .tail_len(tl[1]),
        .frame_tail_leave(ftl[1]), .bus(bif1), .burst_done(bdone[1]), .tail_done(tdone[1]),
        .outstanding(ost[1]), .err_orphan(orph[1]));

    // ---------------- behavioural model ----------------
    int mq_len [2][$];
    bit mq_tl  [2][$];
    int m_state [2];
    int m_cnt [2];
    bit m_trig [2];
    bit m_valid [2];
    bit m_tail [2];
    int m_len [2];
    bit m_bd [2];
    bit m_td [2];
    bit m_or [2];

    task automatic model_reset(input int i);
        mq_len[i].delete();
        mq_tl[i].delete();
        m_state[i] = ST_SETTLE;
        m_cnt[i] = 0; m_trig[i] = 0; m_valid[i] = 0; m_tail[i] = 0; m_len[i] = 0;
        m_bd[i] = 0; m_td[i] = 0; m_or[i] = 0;
    endtask

    task automatic model_step(input int i);
        int  occ, pend, len, c, th;
        bit  acc, d, tflag, fits, nt;
        occ = mq_len[i].size();
        pend = 0;
        for (int k = 0; k < occ; k++) pend += mq_len[i][k];
        acc = m_valid[i] && resp[i];
        d   = dn[i];
        c   = int'(cnt[i]);
        th  = int'(thr[i]);
        m_bd[i] = 0;
        m_td[i] = 0;
        m_or[i] = d && (occ == 0);
        if (fs[i] && m_state[i] != ST_SETTLE) begin
            mq_len[i].delete();
            mq_tl[i].delete();
            m_state[i] = ST_SETTLE; m_cnt[i] = 0; m_trig[i] = 0; m_valid[i] = 0;
            return;
        end
        tflag = ts[i] || (m_state[i] == ST_LAST);
        len   = tflag ? int'(tl[i]) : int'(bl[i]);
        if (i == 1) fits = (c >= pend + len) && (c - pend > th);
        else        fits = (c + pend + len <= FULL) && (c + pend < FULL - th);
        nt = en[i] && !fs[i] && (m_state[i] == ST_RUN || m_state[i] == ST_LAST) &&
             (occ < MAXO) && !m_trig[i] && !m_valid[i] && fits;
        if (d && occ > 0) begin
            m_bd[i] = !mq_tl[i][0];
            void'(mq_len[i].pop_front());
            void'(mq_tl[i].pop_front());
        end
        if (acc) begin
            mq_len[i].push_back(m_len[i]);
            mq_tl[i].push_back(m_tail[i]);
        end
        case (m_state[i])
            ST_SETTLE: begin
                if (fs[i]) m_cnt[i] = 0;
                else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == SETTLE) begin m_cnt[i] = 0; m_state[i] = ST_RUN; end
                end
            end
            ST_RUN:   if (acc && m_tail[i]) m_state[i] = ST_TWAIT;
            ST_TWAIT: if (occ == 0) begin
                m_td[i] = 1;
                m_state[i] = (i == 0) ? (ftl[i] ? ST_LAST : ST_RUN) : ST_HOLD;
            end
            ST_LAST:  if (acc) m_state[i] = ST_LWAIT;
            ST_LWAIT: if (occ == 0) begin m_td[i] = 1; m_state[i] = ST_HOLD; end
            default: ;
        endcase
        if (acc) m_valid[i] = 0;
        else if (m_trig[i]) m_valid[i] = 1;
        if (nt) begin m_len[i] = len; m_tail[i] = tflag; end
        m_trig[i] = nt;
    endtask

    always @(posedge clock or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else model_step(i);
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;
    int bd_n [2];
    int td_n [2];
    int or_n [2];
    int tail_reqs [2];
    bit prev_rv [2];

    task automatic chk(input string nm, input int inst, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s[%0d] got %0d expected %0d", nm, inst, got, exp);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            bd_n[i] = 0; td_n[i] = 0; or_n[i] = 0; tail_reqs[i] = 0;
        end
    endtask

    // Advance to the next falling edge, compare every output against the model, tally pulses.
    task automatic tick();
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("req_valid", i, int'(rv[i]), int'(m_valid[i]));
            chk("burst_done", i, int'(bdone[i]), int'(m_bd[i]));
            chk("tail_done", i, int'(tdone[i]), int'(m_td[i]));
            chk("err_orphan", i, int'(orph[i]), int'(m_or[i]));
            chk("outstanding", i, int'(ost[i]), mq_len[i].size());
            if (m_valid[i]) begin
                chk("req_len", i, int'(rl[i]), m_len[i]);
                chk("req_tail", i, int'(rt[i]), int'(m_tail[i]));
            end
            if (rv[i] && !prev_rv[i] && rt[i] && rl[i] == 9'd37) tail_reqs[i]++;
            prev_rv[i] = rv[i];
            bd_n[i] += int'(bdone[i]);
            td_n[i] += int'(tdone[i]);
            or_n[i] += int'(orph[i]);
        end
    endtask

    task automatic auto_done();
        for (int i = 0; i < 2; i++) dn[i] = (mq_len[i].size() > 0) && ($urandom % 2 == 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 1; cnt[i] = 0; thr[i] = 0; bl[i] = 0; fs[i] = 0; ts[i] = 0;
            tl[i] = 0; ftl[i] = 0; resp[i] = 0; dn[i] = 0; prev_rv[i] = 0;
        end
        clear_counts();
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_valid", i, int'(rv[i]), 0);
            chk("rst_outstanding", i, int'(ost[i]), 0);
            chk("rst_req_len", i, int'(rl[i]), 0);
            chk("rst_pulses", i, int'(bdone[i]) + int'(tdone[i]) + int'(orph[i]), 0);
        end

        // Settle then first burst; done withheld so in-flight lengths cap issue at two.
        cnt[0] = 0;   thr[0] = 56; bl[0] = 100;
        cnt[1] = 150; thr[1] = 20; bl[1] = 64;
        resp[0] = 1; resp[1] = 1;
        rst = 0;
        repeat (32) tick();
        for (int i = 0; i < 2; i++) chk("settle_quiet", i, int'(rv[i]), 0);
        tick();
        chk("first_valid", 0, int'(rv[0]), 1);
        chk("first_len", 0, int'(rl[0]), 100);
        chk("model_first_len", 0, m_len[0], 100);
        chk("first_tail", 0, int'(rt[0]), 0);
        chk("first_valid", 1, int'(rv[1]), 1);
        chk("first_len", 1, int'(rl[1]), 64);
        repeat (20) tick();
        for (int i = 0; i < 2; i++) begin
            chk("two_in_flight", i, int'(ost[i]), 2);
            chk("model_two_in_flight", i, mq_len[i].size(), 2);
        end
        dn[0] = 1; dn[1] = 1;
        tick();
        dn[0] = 0; dn[1] = 0;
        for (int i = 0; i < 2; i++) begin
            chk("done_burst_pulse", i, int'(bdone[i]), 1);
            chk("after_done_ost", i, int'(ost[i]), 1);
        end
        repeat (10) tick();
        for (int i = 0; i < 2; i++) chk("refill_ost", i, int'(ost[i]), 2);

        // Accept and done in the same cycle.
        resp[0] = 0; resp[1] = 0; dn[0] = 1; dn[1] = 1;
        tick();
        dn[0] = 0; dn[1] = 0;
        repeat (5) tick();
        for (int i = 0; i < 2; i++) chk("held_valid", i, int'(rv[i]), 1);
        resp[0] = 1; resp[1] = 1; dn[0] = 1; dn[1] = 1;
        tick();
        dn[0] = 0; dn[1] = 0;
        for (int i = 0; i < 2; i++) begin
            chk("pushpop_ost", i, int'(ost[i]), 1);
            chk("pushpop_valid_low", i, int'(rv[i]), 0);
        end
        repeat (10) tick();
        for (int i = 0; i < 2; i++) chk("pushpop_refill", i, int'(ost[i]), 2);

        // Three in flight, then fsync abort and orphan completions.
        thr[0] = 40; bl[0] = 50; cnt[1] = 255;
        repeat (15) tick();
        for (int i = 0; i < 2; i++) chk("three_in_flight", i, int'(ost[i]), 3);
        fs[0] = 1; fs[1] = 1;
        tick();
        fs[0] = 0; fs[1] = 0;
        for (int i = 0; i < 2; i++) chk("abort_ost", i, int'(ost[i]), 0);
        clear_counts();
        dn[0] = 1; dn[1] = 1; tick();
        dn[0] = 0; dn[1] = 0; tick();
        dn[0] = 1; dn[1] = 1; tick();
        dn[0] = 0; dn[1] = 0; tick();
        for (int i = 0; i < 2; i++) begin
            chk("orphan_pulses", i, or_n[i], 2);
            chk("orphan_no_burst_done", i, bd_n[i], 0);
        end

        // Tail sequence: LINE instance issues tail + last tail, ONCE instance a single tail.
        for (int i = 0; i < 2; i++) begin
            ts[i] = 1; tl[i] = 37; ftl[i] = 1; resp[i] = 1; thr[i] = 20;
        end
        cnt[0] = 0; cnt[1] = 150;
        clear_counts();
        for (int k = 0; k < 150; k++) begin
            tick();
            auto_done();
        end
        dn[0] = 0; dn[1] = 0;
        chk("line_tail_done_count", 0, td_n[0], 2);
        chk("line_tail_reqs", 0, tail_reqs[0], 2);
        chk("once_tail_done_count", 1, td_n[1], 1);
        chk("once_tail_reqs", 1, tail_reqs[1], 1);
        chk("model_hold", 0, m_state[0], ST_HOLD);
        chk("model_hold", 1, m_state[1], ST_HOLD);
        fs[0] = 1; fs[1] = 1;
        tick();
        fs[0] = 0; fs[1] = 0;
        tick();
        for (int i = 0; i < 2; i++) chk("model_resettle", i, m_state[i], ST_SETTLE);

        // Randomised traffic with a mid-run asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) rst = 1;
            if (c == 1503) rst = 0;
            for (int i = 0; i < 2; i++) begin
                en[i]   = ($urandom % 16) != 0;
                cnt[i]  = (i == 0) ? 10'($urandom % 257) : 10'($urandom % 400);
                thr[i]  = 10'($urandom % 80);
                bl[i]   = 9'($urandom_range(120, 1));
                tl[i]   = 9'($urandom_range(120, 1));
                fs[i]   = ($urandom % 150) == 0;
                ts[i]   = ($urandom % 8) == 0;
                ftl[i]  = ($urandom % 2) == 1;
                resp[i] = ($urandom % 2) == 1;
                dn[i]   = (mq_len[i].size() > 0) ? (($urandom % 5) < 2) : (($urandom % 60) == 0);
            end
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
